div_scaler: RTL and testbench

DIV_SCALER -- requirements
Module: div_scaler

---
 rtl/scaler_pkg.sv | 43 ++++
 rtl/div_scaler.sv | 142 ++++++++++++++
 tb/tb_div_scaler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/scaler_pkg.sv
// Shared definitions for the fixed-point scaler blocks: default widths, the
// divider state encoding and the signed clamp applied to quotient magnitudes.
package scaler_pkg;

    localparam int FEATURE_WIDTH_DEF = 32;
    localparam int FRAC_BITS_DEF     = 16;
    localparam int MAX_W             = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Turns an unsigned magnitude plus sign into a width-bit two's complement
    // value, saturating asymmetrically so -2^(width-1) stays representable.
    function automatic logic [MAX_W-1:0] clampResult(
        input  logic [MAX_W-1:0] mag,
        input  logic             neg,
        input  int               width,
        output logic             sat
    );
        logic [MAX_W-1:0] limit;
        limit = MAX_W'(1) << (width - 1);
        sat   = 1'b0;
        if (neg) begin
            if (mag > limit) begin
                sat         = 1'b1;
                clampResult = MAX_W'(0) - limit;
            end else begin
                clampResult = MAX_W'(0) - mag;
            end
        end else begin
            if (mag > (limit - MAX_W'(1))) begin
                sat         = 1'b1;
                clampResult = limit - MAX_W'(1);
            end else begin
                clampResult = mag;
            end
        end
    endfunction

endpackage

// File: rtl/div_scaler.sv
// Signed fixed-point divider: out = (in1 << FRAC_BITS) / in2, computed by a
// bit-serial restoring divider on magnitudes, then signed and clamped.
module div_scaler
    import scaler_pkg::*;
#(
    parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEF,
    parameter int FRAC_BITS     = FRAC_BITS_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [FEATURE_WIDTH-1:0] in1,
    input  logic signed [FEATURE_WIDTH-1:0] in2,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [FEATURE_WIDTH-1:0] out,
    output logic                            div_by_zero,
    output logic                            sat
);

    localparam int QW = FEATURE_WIDTH + FRAC_BITS;
    localparam int CW = $clog2(QW + 1);

    state_t                   r_state;
    state_t                   w_nextState;
    logic [QW-1:0]            r_quot;
    logic [FEATURE_WIDTH:0]   r_rem;
    logic [FEATURE_WIDTH:0]   r_div;
    logic                     r_neg;
    logic [CW-1:0]            r_count;
    logic [FEATURE_WIDTH-1:0] r_out;
    logic                     r_dbz;
    logic                     r_sat;

    logic                     w_accept;
    logic                     w_zeroDiv;
    logic                     w_lastStep;
    logic [FEATURE_WIDTH:0]   w_mag1;
    logic [FEATURE_WIDTH:0]   w_mag2;
    logic [FEATURE_WIDTH+1:0] w_remShift;
    logic                     w_qBit;
    logic [FEATURE_WIDTH:0]   w_remNext;
    logic [QW-1:0]            w_quotNext;
    logic [FEATURE_WIDTH-1:0] w_clamped;
    logic                     w_clampSat;

    // One extra magnitude bit keeps the most-negative operand from wrapping.
    assign w_mag1     = in1[FEATURE_WIDTH-1] ? (~{in1[FEATURE_WIDTH-1], in1} + 1'b1)
                                             : {1'b0, in1};
    assign w_mag2     = in2[FEATURE_WIDTH-1] ? (~{in2[FEATURE_WIDTH-1], in2} + 1'b1)
                                             : {1'b0, in2};
    assign w_zeroDiv  = (in2 == '0);
    assign w_accept   = (r_state == IDLE) && in_valid;
    assign w_lastStep = (r_count == CW'(QW - 1));

    assign w_remShift = {r_rem, r_quot[QW-1]};
    assign w_qBit     = (w_remShift >= {1'b0, r_div});
    assign w_remNext  = w_qBit ? (FEATURE_WIDTH + 1)'(w_remShift - {1'b0, r_div})
                               : (FEATURE_WIDTH + 1)'(w_remShift);
    assign w_quotNext = {r_quot[QW-2:0], w_qBit};

    always_comb begin
        w_clampSat = 1'b0;
        w_clamped  = FEATURE_WIDTH'(clampResult(MAX_W'(w_quotNext), r_neg, FEATURE_WIDTH, w_clampSat));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = w_zeroDiv ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_lastStep) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Result registers only change on acceptance or the final divide step,
    // so they stay frozen for as long as DONE is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quot  <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_neg   <= 1'b0;
            r_count <= '0;
            r_out   <= '0;
            r_dbz   <= 1'b0;
            r_sat   <= 1'b0;
        end else if (w_accept) begin
            r_quot  <= QW'({w_mag1, {FRAC_BITS{1'b0}}});
            r_rem   <= '0;
            r_div   <= w_mag2;
            r_neg   <= in1[FEATURE_WIDTH-1] ^ in2[FEATURE_WIDTH-1];
            r_count <= '0;
            r_sat   <= 1'b0;
            r_dbz   <= w_zeroDiv;
            if (w_zeroDiv) begin
                r_out <= in1[FEATURE_WIDTH-1] ? {1'b1, {(FEATURE_WIDTH-1){1'b0}}}
                                              : {1'b0, {(FEATURE_WIDTH-1){1'b1}}};
            end
        end else if (r_state == CALC) begin
            r_quot  <= w_quotNext;
            r_rem   <= w_remNext;
            r_count <= r_count + 1'b1;
            if (w_lastStep) begin
                r_out <= w_clamped;
                r_sat <= w_clampSat;
                r_dbz <= 1'b0;
            end
        end
    end

    assign out         = r_out;
    assign div_by_zero = r_dbz;
    assign sat         = r_sat;

endmodule

// File: tb/tb_div_scaler.sv
// Directed bench for div_scaler: each operation pushes its expected result to a
// scoreboard, and the popped entry is checked when the divider presents output.
module tb_div_scaler;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in1;
    logic signed [31:0] in2;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out;
    logic               div_by_zero;
    logic               sat;

    typedef struct {
        logic [31:0] out;
        logic        dbz;
        logic        sat;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    div_scaler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in1        (in1),
        .in2        (in2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .div_by_zero(div_by_zero),
        .sat        (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one operand pair, returns once out_valid is up (or the bound expires).
    task automatic startOp(input logic [31:0] a, input logic [31:0] b, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        compare("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1      = $urandom;
        in2      = $urandom;
        compare("in_ready_after_accept", {63'd0, in_ready}, 64'd0);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic checkOutput(input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            compare("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        compare({e.tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        compare({e.tag, "_out"}, {32'd0, out}, {32'd0, e.out});
        compare({e.tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
        compare({e.tag, "_sat"}, {63'd0, sat}, {63'd0, e.sat});
        compare({e.tag, "_latency"}, 64'(lat), 64'(e.lat));
        @(negedge clk);
        out_ready = 1'b1;
        compare({e.tag, "_in_ready_pop_cycle"}, {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        compare({e.tag, "_valid_after_pop"}, {63'd0, out_valid}, 64'd0);
        compare({e.tag, "_in_ready_after_pop"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eOut, input logic eDbz,
                                 input logic eSat, input int eLat, input string tag);
        exp_t e;
        int   lat;
        e.out = eOut;
        e.dbz = eDbz;
        e.sat = eSat;
        e.lat = eLat;
        e.tag = tag;
        sb.push_back(e);
        startOp(a, b, lat);
        checkOutput(lat);
    endtask

    initial begin
        exp_t e;
        int   lat;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in1       = '0;
        in2       = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2;
        compare("reset_in_ready", {63'd0, in_ready}, 64'd1);
        compare("reset_out_valid", {63'd0, out_valid}, 64'd0);
        compare("reset_out", {32'd0, out}, 64'd0);
        compare("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        compare("reset_sat", {63'd0, sat}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 49, "one_by_one");
        applyStimulus(32'h0006_0000, 32'hFFFE_0000, 32'hFFFD_0000, 1'b0, 1'b0, 49, "six_by_neg_two");
        applyStimulus(32'hFFFF_FFF9, 32'h0002_0000, 32'hFFFF_FFFD, 1'b0, 1'b0, 49, "trunc_toward_zero");
        applyStimulus(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 49, "one_point_five");
        applyStimulus(32'hFFFD_0000, 32'hFFFF_0000, 32'h0003_0000, 1'b0, 1'b0, 49, "neg_by_neg");
        applyStimulus(32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1,  "dbz_pos");
        applyStimulus(32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1,  "dbz_neg");
        applyStimulus(32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1,  "dbz_zero");
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 49, "sat_pos");
        applyStimulus(32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 49, "most_neg_exact");
        applyStimulus(32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 49, "sat_neg");

        // Back-pressure: result must hold while the consumer stalls, and new operands are ignored.
        e.out = 32'h0002_0000;
        e.dbz = 1'b0;
        e.sat = 1'b0;
        e.lat = 49;
        e.tag = "stall";
        sb.push_back(e);
        startOp(32'h0004_0000, 32'h0002_0000, lat);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in1      = $urandom;
            in2      = $urandom;
            compare("stall_valid", {63'd0, out_valid}, 64'd1);
            compare("stall_out", {32'd0, out}, {32'd0, sb[0].out});
            compare("stall_dbz", {63'd0, div_by_zero}, 64'd0);
            compare("stall_sat", {63'd0, sat}, 64'd0);
            compare("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        checkOutput(lat);

        // Reset in the middle of a divide abandons it; the next op behaves as from power-up.
        @(negedge clk);
        in1      = 32'h0005_0000;
        in2      = 32'h0001_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        compare("midcalc_reset_valid", {63'd0, out_valid}, 64'd0);
        compare("midcalc_reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                compare("midcalc_no_result", {63'd0, out_valid}, 64'd0);
            end
        end
        applyStimulus(32'h0003_0000, 32'h0001_0000, 32'h0003_0000, 1'b0, 1'b0, 49, "after_reset");

        compare("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
